// File: rtl/uart_dev_if.sv
// Bridge-side register bus for uart_dev: word address, write strobe, write data and combinational read data.
interface uart_dev_if;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (output Addr, WE, Din, input Dout);
  modport slave  (input Addr, WE, Din, output Dout);
endinterface

// File: rtl/uart_dev.sv
// Memory-mapped 8N1 UART (DATA/STATUS/CTRL/DIVISOR) with level IRQ; UART_LOOPBACK_EN feeds tx into the RX synchroniser.
// Latency: reads are combinational; tx falls on the accepting write edge; rx_valid 2+DIV/2+9*DIV cycles after the start edge.
// Backpressure: none on the bus; a DATA write while TX is busy is dropped.
module uart_dev #(
  parameter int DIV_RESET = 434
) (
  input  logic      clk,
  input  logic      reset,
  uart_dev_if.slave bus,
  output logic      IRQ,
  output logic      tx,
  input  logic      rx
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [15:0] divisor;
  logic [1:0]  ctrl;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_overrun;
  logic        frame_err;

  state_t      tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_idle;
  logic        tx_start;

  state_t      rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_src;
  logic        rx_s1;
  logic        rx_s2;

  logic        wr_data;
  logic        wr_status;
  logic        wr_ctrl;
  logic        wr_div;
  logic        clr_valid;
  logic        clr_ovr;
  logic        clr_ferr;
  logic        unused_bits;

  assign wr_data   = bus.WE && (bus.Addr[1:0] == 2'd0);
  assign wr_status = bus.WE && (bus.Addr[1:0] == 2'd1);
  assign wr_ctrl   = bus.WE && (bus.Addr[1:0] == 2'd2);
  assign wr_div    = bus.WE && (bus.Addr[1:0] == 2'd3);
  assign clr_valid = wr_status && bus.Din[1];
  assign clr_ovr   = wr_status && bus.Din[2];
  assign clr_ferr  = wr_status && bus.Din[3];

  assign unused_bits = ^{bus.Addr[29:2], bus.Din[31:16]};

  assign tx_idle = (tx_state == S_IDLE);
  // A write landing on the edge that ends the stop bit chains straight into the next frame.
  assign tx_start = wr_data && (tx_idle || (tx_state == S_STOP && tx_cnt == 16'd0));

  assign IRQ = (ctrl[0] & tx_idle) | (ctrl[1] & rx_valid);

  always_comb begin
    bus.Dout = 32'h0;
    case (bus.Addr[1:0])
      2'd0:    bus.Dout = {24'h0, rx_byte};
      2'd1:    bus.Dout = {28'h0, frame_err, rx_overrun, rx_valid, tx_idle};
      2'd2:    bus.Dout = {30'h0, ctrl};
      default: bus.Dout = {16'h0, divisor};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divisor <= 16'(DIV_RESET);
      ctrl    <= 2'b00;
    end else begin
      if (wr_ctrl) ctrl <= bus.Din[1:0];
      if (wr_div)  divisor <= (bus.Din[15:0] < 16'd2) ? 16'd2 : bus.Din[15:0];
    end
  end

  // Bit length is reloaded from divisor only at each bit start, so a mid-frame write never stretches the current bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
      tx       <= 1'b1;
    end else if (tx_start) begin
      tx_state <= S_START;
      tx_cnt   <= divisor - 16'd1;
      tx_bit   <= 3'd0;
      tx_shift <= bus.Din[7:0];
      tx       <= 1'b0;
    end else if (!tx_idle) begin
      if (tx_cnt != 16'd0) begin
        tx_cnt <= tx_cnt - 16'd1;
      end else begin
        tx_cnt <= divisor - 16'd1;
        case (tx_state)
          S_START: begin
            tx_state <= S_DATA;
            tx_bit   <= 3'd0;
            tx       <= tx_shift[0];
          end
          S_DATA: begin
            if (tx_bit == 3'd7) begin
              tx_state <= S_STOP;
              tx       <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= tx_shift >> 1;
              tx       <= tx_shift[1];
            end
          end
          default: tx_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef UART_LOOPBACK_EN
  logic unused_rx;
  assign unused_rx = rx;
  assign rx_src    = tx;
`else
  assign rx_src = rx;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx_src;
      rx_s2 <= rx_s1;
    end
  end

  // Status flags share this block with the RX FSM so a setting event, written last, overrides a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state   <= S_IDLE;
      rx_cnt     <= 16'd0;
      rx_bit     <= 3'd0;
      rx_shift   <= 8'h00;
      rx_byte    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (clr_valid) rx_valid   <= 1'b0;
      if (clr_ovr)   rx_overrun <= 1'b0;
      if (clr_ferr)  frame_err  <= 1'b0;
      if (rx_state == S_IDLE) begin
        if (!rx_s2) begin
          rx_state <= S_START;
          rx_cnt   <= (divisor >> 1) - 16'd1;
        end
      end else if (rx_cnt != 16'd0) begin
        rx_cnt <= rx_cnt - 16'd1;
      end else begin
        rx_cnt <= divisor - 16'd1;
        case (rx_state)
          S_START: begin
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
            rx_bit   <= 3'd0;
          end
          S_DATA: begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end
          S_STOP: begin
            rx_state <= S_IDLE;
            if (!rx_s2) begin
              frame_err <= 1'b1;
            end else if (!rx_valid || clr_valid) begin
              rx_byte  <= rx_shift;
              rx_valid <= 1'b1;
            end else begin
              rx_overrun <= 1'b1;
            end
          end
          default: rx_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/uart_dev.md
# uart_dev

Memory-mapped UART peripheral that sits on the device side of the CPU–bridge bus, next to the two timers. It decodes word writes from the bridge (Addr/WE/Din) and returns register data combinationally on Dout. It serialises bytes onto `tx`, deserialises bytes from `rx`, and raises a level interrupt that the top level feeds into HWInt[3].

## Interface
- DIV_RESET, 434: reset value of DIVISOR, in clock cycles per bit; must be ≥ 2.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (reset = 0 clears the block).
- Addr  in  30  word address (bus address [31:2]); only Addr[1:0] is decoded.
- WE  in  1  write strobe; a write occurs at the edge where WE = 1.
- Din  in  32  write data.
- Dout  out  32  read data, a combinational mux on Addr[1:0].
- IRQ  out  1  level interrupt request.
- tx  out  1  serial output, idle high.
- rx  in  1  serial input, asynchronous to clk.

## Operation
- Register map by Addr[1:0]. Unused read bits return 0.
  - 0 DATA
    - Write: loads Din[7:0] and starts a frame if TX is IDLE. If TX is busy, the write is silently dropped.
    - Read: {24'b0, rx_byte}.
  - 1 STATUS
    - Read: bit0 tx_idle, bit1 rx_valid, bit2 rx_overrun, bit3 frame_err.
    - Write: write-1-to-clear on bits 1–3. Bit 0 ignores writes.
  - 2 CTRL: bit0 tx_irq_en, bit1 rx_irq_en. Read/write.
  - 3 DIVISOR: bits[15:0], read/write. Any written value below 2 is stored as 2.
- IRQ = (tx_irq_en & tx_idle) | (rx_irq_en & rx_valid). It is combinational from registers and has no glitch-producing inputs.
- Frame format: 8N1, LSB first; each bit lasts DIVISOR cycles.
- TX FSM: IDLE → START → DATA (8 bits, bit counter 0..7) → STOP → IDLE.
  - tx = 0 in START, the data bit in DATA, 1 in STOP and IDLE.
  - tx_idle = (state == IDLE).
- RX path: rx passes through a 2-flop synchroniser before any use.
- RX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE → START when the synchronised rx = 0.
  - START: wait DIVISOR/2 (floor) cycles, then re-sample. If rx = 1, treat as a glitch and return to IDLE. If rx = 0, go to DATA.
  - DATA: sample every DIVISOR cycles, i.e. mid-bit, 8 samples.
  - STOP: sample once after DIVISOR cycles.
    - Stop bit = 0: set frame_err and discard the byte.
    - Stop bit = 1 and rx_valid = 0: store rx_byte and set rx_valid.
    - Stop bit = 1 and rx_valid = 1: set rx_overrun; rx_byte is unchanged.
- Simultaneous events:
  - STATUS W1C of rx_valid in the same cycle as a good stop bit: new byte stored, rx_valid stays 1, no overrun.
  - W1C of frame_err/rx_overrun in the same cycle as a new setting event: set wins.
- A DIVISOR write mid-frame takes effect at the next bit-period start, for both FSMs. The current bit keeps the old length.

## Timing
- Reset values:
  - tx = 1; IRQ = 0; both FSMs IDLE.
  - DIVISOR = DIV_RESET; CTRL = 0; rx_byte = 0; STATUS = 0x1.
  - Dout therefore reads 0, 0x1, 0, DIV_RESET for offsets 0–3.
- Reset asserted mid-frame aborts it immediately. tx returns to 1 asynchronously.
- Register writes are visible on Dout from the cycle after the write edge.
- TX latency:
  - tx falls at the same edge that accepts the DATA write.
  - The frame occupies exactly 10×DIVISOR cycles.
  - tx_idle rises at the edge ending the stop bit.
  - A DATA write on that same edge is accepted.
- RX latency: rx_valid rises (2 + DIVISOR/2 + 9×DIVISOR) cycles after the rx falling edge, ±1 cycle for synchroniser phase.
- Read path has zero latency. Reads have no side effects.

## Configuration
- UART_LOOPBACK_EN defined:
  - The RX synchroniser input is driven internally from tx.
  - The external rx pin is ignored.
  - The tx pin is still driven normally.
- UART_LOOPBACK_EN undefined: RX samples the external rx pin.

## Test plan
- Reset: hold reset = 0 with Addr = 1 → Dout = 0x1, IRQ = 0, tx = 1. Read offset 3 → DIV_RESET.
- TX frame:
  - Stimulus: DIVISOR = 4; write DATA = 0xA5.
  - Required tx sequence, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1, 1.
  - tx_idle = 0 for exactly 40 cycles.
  - A second DATA write 0x3C issued mid-frame is dropped, with no second frame.
- RX + IRQ:
  - Stimulus: DIVISOR = 4, CTRL = 0x2; drive frame 0x5A on rx.
  - Required: rx_valid = 1, Dout@0 = 0x5A, IRQ = 1.
  - Write STATUS = 0x2 → rx_valid = 0, IRQ = 0.
- Overrun / frame error:
  - Two frames 0x11 then 0x22 without clearing → rx_byte = 0x11, rx_overrun = 1.
  - A frame with stop bit = 0 → frame_err = 1, rx_valid unchanged.
- Glitch and clamp:
  - A 1-cycle low pulse on rx → no state change.
  - Write DIVISOR = 0 → reads back 2.
  - Reset = 0 mid-TX → tx = 1 immediately.
- Loopback (UART_LOOPBACK_EN):
  - Stimulus: write DATA = 0xC3 with rx held at 0.
  - Required: rx_valid = 1 and rx_byte = 0xC3 after the frame.
